// File: rtl/ticket_purchase_ctrl.sv
// Host-side controller that feeds up to four bills into a ticket machine and
// reports the outcome (dispensed, returned, underpaid, protocol error).
module ticket_purchase_ctrl #(
    parameter int RDY_TIMEOUT = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [7:0]       req_bills,
    input  logic             ready,
    input  logic             dispense,
    input  logic             return_sig,
    input  logic             bill,
    output logic             ten,
    output logic             twenty,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] ticket_count,
    output logic [CNT_W-1:0] return_count
);

    localparam int TW = $clog2(RDY_TIMEOUT + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(RDY_TIMEOUT - 1);

    localparam logic [1:0] CODE_TEN    = 2'b01;
    localparam logic [1:0] CODE_TWENTY = 2'b10;
    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_RET      = 2'b01;
    localparam logic [1:0] ST_UNDER    = 2'b10;
    localparam logic [1:0] ST_ERR      = 2'b11;

    typedef enum logic [2:0] {IDLE, WAIT_RDY, INSERT, CHECK, FINISH} state_t;

    state_t          state_r;
    logic [7:0]      bills_r;
    logic [2:0]      slot_r;
    logic [5:0]      total_r;
    logic [TW-1:0]   tmo_r;

    logic [1:0]      cur_code_s;
    logic [1:0]      next_code_s;
    logic [2:0]      next_slot_s;
    logic [5:0]      bill_val_s;
    logic [2:0]      exp_s;
    logic            check_ok_s;
    logic            next_is_bill_s;

    function automatic logic [1:0] code_at(input logic [7:0] bills, input logic [2:0] idx);
        logic [1:0] code;
        case (idx)
            3'd0:    code = bills[1:0];
            3'd1:    code = bills[3:2];
            3'd2:    code = bills[5:4];
            3'd3:    code = bills[7:6];
            default: code = 2'b00;
        endcase
        return code;
    endfunction

    function automatic logic is_bill(input logic [1:0] code);
        return (code == CODE_TEN) || (code == CODE_TWENTY);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
    endfunction

    // Decode current/next bill and the machine response expected for the running total
    always_comb begin
        cur_code_s     = code_at(bills_r, slot_r);
        next_slot_s    = slot_r + 3'd1;
        next_code_s    = code_at(bills_r, next_slot_s);
        next_is_bill_s = (next_slot_s < 3'd4) && is_bill(next_code_s);
        if (cur_code_s == CODE_TWENTY) begin
            bill_val_s = 6'd20;
        end else begin
            bill_val_s = 6'd10;
        end
        // expected {bill, dispense, return_sig}; totals above 50 cannot occur
        if (total_r < 6'd40) begin
            exp_s = 3'b100;
        end else if (total_r == 6'd40) begin
            exp_s = 3'b010;
        end else if (total_r == 6'd50) begin
            exp_s = 3'b001;
        end else begin
            exp_s = 3'b111;
        end
        check_ok_s = ({bill, dispense, return_sig} == exp_s);
    end

    // Purchase state machine with registered handshake, pulse and result outputs
    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_r      <= IDLE;
            bills_r      <= 8'd0;
            slot_r       <= 3'd0;
            total_r      <= 6'd0;
            tmo_r        <= '0;
            req_ready    <= 1'b1;
            ten          <= 1'b0;
            twenty       <= 1'b0;
            done         <= 1'b0;
            status       <= ST_OK;
            ticket_count <= '0;
            return_count <= '0;
        end else begin
            ten    <= 1'b0;
            twenty <= 1'b0;
            done   <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        bills_r   <= req_bills;
                        slot_r    <= 3'd0;
                        total_r   <= 6'd0;
                        tmo_r     <= '0;
                        req_ready <= 1'b0;
                        if (is_bill(req_bills[1:0])) begin
                            state_r <= WAIT_RDY;
                        end else begin
                            state_r <= FINISH;
                            done    <= 1'b1;
                            status  <= ST_UNDER;
                        end
                    end
                end
                WAIT_RDY: begin
                    if (ready) begin
                        state_r <= INSERT;
                        ten     <= (cur_code_s == CODE_TEN);
                        twenty  <= (cur_code_s == CODE_TWENTY);
                    end else if (tmo_r == TMO_LAST) begin
                        state_r <= FINISH;
                        done    <= 1'b1;
                        status  <= ST_ERR;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                INSERT: begin
                    total_r <= total_r + bill_val_s;
                    state_r <= CHECK;
                end
                CHECK: begin
                    if (!check_ok_s) begin
                        state_r <= FINISH;
                        done    <= 1'b1;
                        status  <= ST_ERR;
                    end else if (total_r == 6'd40) begin
                        state_r      <= FINISH;
                        done         <= 1'b1;
                        status       <= ST_OK;
                        ticket_count <= sat_inc(ticket_count);
                    end else if (total_r == 6'd50) begin
                        state_r      <= FINISH;
                        done         <= 1'b1;
                        status       <= ST_RET;
                        return_count <= sat_inc(return_count);
                    end else begin
                        slot_r <= next_slot_s;
                        if (next_is_bill_s) begin
                            state_r <= INSERT;
                            ten     <= (next_code_s == CODE_TEN);
                            twenty  <= (next_code_s == CODE_TWENTY);
                        end else begin
                            state_r <= FINISH;
                            done    <= 1'b1;
                            status  <= ST_UNDER;
                        end
                    end
                end
                FINISH: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                end
                default: begin
                    state_r   <= IDLE;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ticket_purchase_ctrl.sv
// Directed bench for ticket_purchase_ctrl with a simple Moore ticket-machine model.
module tb_ticket_purchase_ctrl;

    logic       clk = 1'b0;
    logic       clear;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_bills;
    logic       ready, dispense, return_sig, bill;
    logic       ten, twenty, done;
    logic [1:0] status;
    logic [7:0] ticket_count, return_count;

    int checks = 0;
    int passes = 0;
    int cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ticket_purchase_ctrl #(.RDY_TIMEOUT(16), .CNT_W(8)) dut (
        .clk(clk), .clear(clear), .req_valid(req_valid), .req_ready(req_ready),
        .req_bills(req_bills), .ready(ready), .dispense(dispense),
        .return_sig(return_sig), .bill(bill), .ten(ten), .twenty(twenty),
        .done(done), .status(status), .ticket_count(ticket_count),
        .return_count(return_count)
    );

    // Ticket machine: 0 idle(ready), 1 holding credit(bill), 2 dispense, 3 return
    logic [1:0] m_st;
    logic [5:0] m_credit;
    logic [5:0] m_next;
    logic       m_clr = 1'b1;
    logic       m_kill = 1'b0;

    assign m_next     = m_credit + (ten ? 6'd10 : 6'd0) + (twenty ? 6'd20 : 6'd0);
    assign ready      = (m_st == 2'd0);
    assign bill       = (m_st == 2'd1) && !m_kill;
    assign dispense   = (m_st == 2'd2);
    assign return_sig = (m_st == 2'd3);

    always @(posedge clk) begin
        if (m_clr) begin
            m_st     <= 2'd0;
            m_credit <= 6'd0;
        end else if (m_st >= 2'd2) begin
            m_st     <= 2'd0;
            m_credit <= 6'd0;
        end else if (ten || twenty) begin
            if (m_next == 6'd40) begin
                m_st <= 2'd2; m_credit <= 6'd0;
            end else if (m_next >= 6'd50) begin
                m_st <= 2'd3; m_credit <= 6'd0;
            end else begin
                m_st <= 2'd1; m_credit <= m_next;
            end
        end
    end

    // Pulse/done monitor sampled away from the active edge
    int ten_cnt = 0, twenty_cnt = 0, done_cnt = 0, both_cnt = 0;
    int last_pulse_cyc = 0, pulse_gap = 0;
    logic [11:0] chk_hist = 12'd0;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (ten && twenty) both_cnt = both_cnt + 1;
        if (prev_pulse) chk_hist = {chk_hist[8:0], bill, dispense, return_sig};
        prev_pulse = ten | twenty;
        if (ten) ten_cnt = ten_cnt + 1;
        if (twenty) twenty_cnt = twenty_cnt + 1;
        if (ten | twenty) begin
            pulse_gap      = cyc - last_pulse_cyc;
            last_pulse_cyc = cyc;
        end
        if (done) done_cnt = done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic run_req(input logic [7:0] b, output logic [1:0] st, output int lat,
                           output logic got);
        int acc;
        got = 1'b0;
        st  = 2'b00;
        lat = -1;
        @(negedge clk);
        req_bills = b;
        req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        acc = cyc;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) begin
                got = 1'b1;
                st  = status;
                lat = cyc - acc;
                break;
            end
        end
        #2;
    endtask

    task automatic pulse_mclr();
        @(negedge clk) m_clr = 1'b1;
        @(negedge clk) m_clr = 1'b0;
        #2;
    endtask

    logic [1:0] st;
    int lat, t0, w0, d0, tmo_fail;
    logic got, seen;

    initial begin
        clear = 1'b1; req_valid = 1'b0; req_bills = 8'h00;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ten", ten, 0);
        chk("rst_twenty", twenty, 0);
        chk("rst_done", done, 0);
        chk("rst_status", status, 0);
        chk("rst_tcount", ticket_count, 0);
        chk("rst_rcount", return_count, 0);
        clear = 1'b0; m_clr = 1'b0;
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);

        // {20,20}: two twenty pulses 2 cycles apart, dispense
        t0 = ten_cnt; w0 = twenty_cnt;
        run_req(8'h0A, st, lat, got);
        chk("a_done", got, 1);
        chk("a_status", st, 2'b00);
        chk("a_twenty", twenty_cnt - w0, 2);
        chk("a_ten", ten_cnt - t0, 0);
        chk("a_gap", pulse_gap, 2);
        chk("a_hist", chk_hist[5:0], 6'b100_010);
        chk("a_tcount", ticket_count, 1);
        @(negedge clk);
        chk("a_done_1cyc", done, 0);

        // {10,10,10,10}: bill at checks 1-3, dispense at check 4
        t0 = ten_cnt;
        run_req(8'h55, st, lat, got);
        chk("b_done", got, 1);
        chk("b_status", st, 2'b00);
        chk("b_ten", ten_cnt - t0, 4);
        chk("b_hist", chk_hist, 12'b100_100_100_010);
        chk("b_tcount", ticket_count, 2);

        // {10,20,20,10}: return at check 3, slot 3 never used
        t0 = ten_cnt; w0 = twenty_cnt;
        run_req(8'h69, st, lat, got);
        chk("c_done", got, 1);
        chk("c_status", st, 2'b01);
        chk("c_ten", ten_cnt - t0, 1);
        chk("c_twenty", twenty_cnt - w0, 2);
        chk("c_hist", chk_hist[8:0], 9'b100_100_001);
        chk("c_rcount", return_count, 1);
        chk("c_tcount", ticket_count, 2);

        // {10,end}: underpaid, machine left holding credit
        t0 = ten_cnt;
        run_req(8'h01, st, lat, got);
        chk("d_done", got, 1);
        chk("d_status", st, 2'b10);
        chk("d_ten", ten_cnt - t0, 1);
        chk("d_tcount", ticket_count, 2);

        // next {20,20} without machine clear: times out after 16 WAIT_RDY cycles
        w0 = twenty_cnt;
        run_req(8'h0A, st, lat, got);
        chk("e_done", got, 1);
        chk("e_status", st, 2'b11);
        chk("e_latency", lat, 16);
        chk("e_twenty", twenty_cnt - w0, 0);
        chk("e_rcount", return_count, 1);

        // machine drops bill after first insert: protocol error
        pulse_mclr();
        m_kill = 1'b1;
        w0 = twenty_cnt;
        run_req(8'h0A, st, lat, got);
        chk("f_done", got, 1);
        chk("f_status", st, 2'b11);
        chk("f_twenty", twenty_cnt - w0, 1);
        chk("f_tcount", ticket_count, 2);
        chk("f_rcount", return_count, 1);
        m_kill = 1'b0;
        pulse_mclr();

        // clear asserted during INSERT
        d0 = done_cnt;
        @(negedge clk);
        req_bills = 8'h0A; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (twenty) begin
                seen = 1'b1;
                break;
            end
        end
        chk("g_insert_seen", seen, 1);
        clear = 1'b1;
        #1;
        chk("g_twenty_drop", twenty, 0);
        chk("g_req_ready", req_ready, 1);
        chk("g_tcount", ticket_count, 0);
        chk("g_status", status, 0);
        @(negedge clk) clear = 1'b0;
        pulse_mclr();
        repeat (5) @(negedge clk);
        #2;
        chk("g_no_done", done_cnt - d0, 0);
        chk("g_idle", req_ready, 1);

        // ticket counter saturates at 255
        tmo_fail = 0;
        for (int k = 0; k < 257; k++) begin
            run_req(8'h0A, st, lat, got);
            if (!got || st != 2'b00) tmo_fail++;
        end
        chk("h_all_ok", tmo_fail, 0);
        chk("h_tcount_sat", ticket_count, 8'hFF);
        chk("h_rcount", return_count, 0);
        chk("never_both", both_cnt, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
